// File: rtl/aemb2_fsl_pkg.sv
// Shared types and constants for the AEMB2 FSL hub.
package aemb2_fsl_pkg;

  // The cwb side always moves full 32-bit words.
  localparam int FSL_DW = 32;

  // Bit positions inside cwb_tga_i.
  localparam int TGA_CTL = 1;
  localparam int TGA_NBK = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } fsl_state_e;

  // One FIFO entry: control flag above the data word.
  typedef struct packed {
    logic              ctl;
    logic [FSL_DW-1:0] dat;
  } fsl_entry_t;

endpackage

// File: rtl/aemb2_fsl_fifo.sv
// Single-clock show-ahead FIFO: the head entry is always visible on headDat.
// Flags come from the registered count, so a push is refused when full even
// if a pop happens in the same cycle.
module aemb2_fsl_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rstN,
  input  logic                       push,
  input  logic [W-1:0]               pushDat,
  input  logic                       pop,
  output logic [W-1:0]               headDat,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic          doPush;
  logic          doPop;

  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign doPush  = push & ~full;
  assign doPop   = pop & ~empty;
  assign headDat = mem[rdPtr];

  // Storage is data only; emptiness is tracked by the count, so no reset here.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushDat;
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/aemb2_fsl_hub.sv
// Multi-channel FSL hub on the AEMB2 cwb port. Each channel owns an outbound
// FIFO (PUT -> m_* stream) and an inbound FIFO (s_* stream -> GET).
// Optional macro AEMB2_FSL_CUT_EN: a blocking GET waiting on an empty inbound
// FIFO takes the arriving stream word directly, saving one cycle of latency.
module aemb2_fsl_hub
  import aemb2_fsl_pkg::*;
#(
  parameter int CHN   = 4,
  parameter int DEPTH = 8,
  parameter int DW    = 32
) (
  input  logic              sys_clk_i,
  input  logic              sys_rst_i,
  input  logic              cwb_stb_i,
  input  logic              cwb_wre_i,
  input  logic [4:0]        cwb_adr_i,
  input  logic [1:0]        cwb_tga_i,
  input  logic [3:0]        cwb_sel_i,
  input  logic [DW-1:0]     cwb_dat_i,
  output logic [DW-1:0]     cwb_dat_o,
  output logic              cwb_ack_o,
  output logic              cwb_fail_o,
  output logic              cwb_err_o,
  output logic [CHN*DW-1:0] m_dat_o,
  output logic [CHN-1:0]    m_ctl_o,
  output logic [CHN-1:0]    m_vld_o,
  input  logic [CHN-1:0]    m_rdy_i,
  input  logic [CHN*DW-1:0] s_dat_i,
  input  logic [CHN-1:0]    s_ctl_i,
  input  logic [CHN-1:0]    s_vld_i,
  output logic [CHN-1:0]    s_rdy_o
);
  localparam int CW = $clog2(DEPTH) + 1;

  fsl_state_e             state;
  fsl_state_e             stateNxt;
  logic [CHN-1:0]         chHit;
  logic [CHN-1:0]         outFull, outEmpty, outPush, outPop;
  logic [CHN-1:0]         inFull, inEmpty, inPush, inPop;
  logic [CHN-1:0][DW:0]   outHead, inHead;
  logic [CHN-1:0][CW-1:0] outCnt, inCnt;
  logic                   badCh, isPut, nbk, ctlFlag;
  logic                   selOutFull, selInEmpty, selSVld, selSCtl;
  logic [DW-1:0]          selSDat;
  fsl_entry_t             selInHead;
  logic                   srv, cut, go;
  logic                   failNxt, errNxt;
  logic [DW-1:0]          datNxt;
  logic                   unusedBits;

  assign isPut   = cwb_wre_i;
  assign nbk     = cwb_tga_i[TGA_NBK];
  assign ctlFlag = cwb_tga_i[TGA_CTL];
  assign badCh   = ({1'b0, cwb_adr_i} >= 6'(CHN));

  // Byte lanes and FIFO counts are not needed by the hub logic.
  assign unusedBits = ^{cwb_sel_i, outCnt, inCnt};

  // Channel decode: pick the addressed channel's flags, head and stream input.
  always_comb begin
    selOutFull = 1'b0;
    selInEmpty = 1'b1;
    selInHead  = '0;
    selSVld    = 1'b0;
    selSCtl    = 1'b0;
    selSDat    = '0;
    for (int c = 0; c < CHN; c++) begin
      if (chHit[c]) begin
        selOutFull = outFull[c];
        selInEmpty = inEmpty[c];
        selInHead  = inHead[c];
        selSVld    = s_vld_i[c];
        selSCtl    = s_ctl_i[c];
        selSDat    = s_dat_i[c*DW +: DW];
      end
    end
  end

  // Bad channels are always "serviceable" so they complete immediately.
  assign srv = badCh | (isPut ? ~selOutFull : ~selInEmpty);

`ifdef AEMB2_FSL_CUT_EN
  assign cut = (state == ST_WAIT) & ~isPut & ~badCh & selInEmpty & selSVld;
`else
  assign cut = 1'b0;
`endif

  // go marks the edge at which the access completes and the FIFO op happens.
  assign go = cwb_stb_i & ((state == ST_IDLE) | (state == ST_WAIT)) & (srv | nbk | cut);

  // Completion values presented with the ack pulse.
  always_comb begin
    failNxt = 1'b0;
    errNxt  = 1'b0;
    datNxt  = '0;
    if (badCh) begin
      failNxt = 1'b1;
      errNxt  = 1'b1;
    end else if (isPut) begin
      failNxt = selOutFull;
    end else if (cut) begin
      datNxt = selSDat;
      errNxt = (selSCtl != ctlFlag);
    end else if (!selInEmpty) begin
      datNxt = selInHead.dat;
      errNxt = (selInHead.ctl != ctlFlag);
    end else begin
      failNxt = 1'b1;
    end
  end

  // Next-state: a blocking miss parks in WAIT; ACK always returns to IDLE.
  always_comb begin
    stateNxt = state;
    case (state)
      ST_IDLE: if (cwb_stb_i) stateNxt = go ? ST_ACK : ST_WAIT;
      ST_WAIT: begin
        if (go)              stateNxt = ST_ACK;
        else if (!cwb_stb_i) stateNxt = ST_IDLE;
      end
      ST_ACK:  stateNxt = ST_IDLE;
      default: stateNxt = ST_IDLE;
    endcase
  end

  // FSM and cwb response registers; response fields are zero outside ack.
  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_i) begin
      state      <= ST_IDLE;
      cwb_ack_o  <= 1'b0;
      cwb_fail_o <= 1'b0;
      cwb_err_o  <= 1'b0;
      cwb_dat_o  <= '0;
    end else begin
      state      <= stateNxt;
      cwb_ack_o  <= go;
      cwb_fail_o <= go & failNxt;
      cwb_err_o  <= go & errNxt;
      cwb_dat_o  <= go ? datNxt : '0;
    end
  end

  for (genvar c = 0; c < CHN; c++) begin : gCh
    assign chHit[c]   = (cwb_adr_i == 5'(c));
    assign outPush[c] = go & isPut & ~badCh & chHit[c] & ~outFull[c];
    assign outPop[c]  = m_rdy_i[c] & ~outEmpty[c];
    assign inPop[c]   = go & ~isPut & ~badCh & ~cut & chHit[c] & ~inEmpty[c];
    // A word taken by the cut-through path must not also land in the FIFO.
    assign inPush[c]  = s_vld_i[c] & ~inFull[c] & ~(cut & chHit[c]);

    assign m_dat_o[c*DW +: DW] = outHead[c][DW-1:0];
    assign m_ctl_o[c]          = outHead[c][DW];
    assign m_vld_o[c]          = ~outEmpty[c];
    assign s_rdy_o[c]          = ~inFull[c];

    aemb2_fsl_fifo #(.W(DW + 1), .DEPTH(DEPTH)) uOut (
      .clk     (sys_clk_i),
      .rstN    (sys_rst_i),
      .push    (outPush[c]),
      .pushDat ({ctlFlag, cwb_dat_i}),
      .pop     (outPop[c]),
      .headDat (outHead[c]),
      .full    (outFull[c]),
      .empty   (outEmpty[c]),
      .count   (outCnt[c])
    );

    aemb2_fsl_fifo #(.W(DW + 1), .DEPTH(DEPTH)) uIn (
      .clk     (sys_clk_i),
      .rstN    (sys_rst_i),
      .push    (inPush[c]),
      .pushDat ({s_ctl_i[c], s_dat_i[c*DW +: DW]}),
      .pop     (inPop[c]),
      .headDat (inHead[c]),
      .full    (inFull[c]),
      .empty   (inEmpty[c]),
      .count   (inCnt[c])
    );
  end

endmodule

// File: tb/tb_aemb2_fsl_hub.sv
// Bench for aemb2_fsl_hub: queue-based channel model plus directed accesses.
`timescale 1ns/1ps
module tb_aemb2_fsl_hub;
  localparam int CHN = 4, DEPTH = 8, DW = 32;
`ifdef AEMB2_FSL_CUT_EN
  localparam int CUT_LAT = 1;
`else
  localparam int CUT_LAT = 2;
`endif

  logic clk = 1'b0, rstN = 1'b0;
  always #5 clk = ~clk;

  logic              stb = 1'b0, wre = 1'b0;
  logic [4:0]        adr = '0;
  logic [1:0]        tga = '0;
  logic [3:0]        sel = 4'hF;
  logic [31:0]       datI = '0, datO;
  logic              ack, fail, err;
  logic [CHN*DW-1:0] mDat, sDat = '0;
  logic [CHN-1:0]    mCtl, mVld, mRdy = '0, sCtl = '0, sVld = '0, sRdy;

  aemb2_fsl_hub #(.CHN(CHN), .DEPTH(DEPTH), .DW(DW)) dut (
    .sys_clk_i(clk), .sys_rst_i(rstN), .cwb_stb_i(stb), .cwb_wre_i(wre),
    .cwb_adr_i(adr), .cwb_tga_i(tga), .cwb_sel_i(sel), .cwb_dat_i(datI),
    .cwb_dat_o(datO), .cwb_ack_o(ack), .cwb_fail_o(fail), .cwb_err_o(err),
    .m_dat_o(mDat), .m_ctl_o(mCtl), .m_vld_o(mVld), .m_rdy_i(mRdy),
    .s_dat_i(sDat), .s_ctl_i(sCtl), .s_vld_i(sVld), .s_rdy_o(sRdy)
  );

  int checks = 0, failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Model: one queue per FIFO plus the single outstanding cwb request.
  logic [32:0] outQ [CHN][$];
  logic [32:0] inQ  [CHN][$];
  bit          pending = 0, started = 0;
  bit          pWre;
  int          pCh;
  logic [1:0]  pTga;
  logic [31:0] pDat;

  always @(posedge clk) begin
    if (!rstN) begin
      for (int c = 0; c < CHN; c++) begin
        outQ[c].delete();
        inQ[c].delete();
      end
      pending = 0;
    end else begin
      for (int c = 0; c < CHN; c++) begin
        if (outQ[c].size() != 0 && mRdy[c]) void'(outQ[c].pop_front());
        if (sVld[c] && inQ[c].size() < DEPTH) inQ[c].push_back({sCtl[c], sDat[c*DW +: DW]});
      end
    end
  end

  logic [32:0] hd;
  logic        eF, eE;
  logic [31:0] eD;
  always @(negedge clk) begin
    if (started) begin
      if (ack) begin
        if (!pending) check("spurious_ack", ack, 1'b0);
        else begin
          eF = 0; eE = 0; eD = '0;
          if (pCh >= CHN) begin
            eF = 1; eE = 1;
          end else if (pWre) begin
            if (outQ[pCh].size() >= DEPTH) eF = 1;
            else outQ[pCh].push_back({pTga[1], pDat});
          end else if (inQ[pCh].size() != 0) begin
            hd = inQ[pCh].pop_front();
            eD = hd[31:0];
            eE = (hd[32] != pTga[1]);
          end else eF = 1;
          check("ack_dat", datO, eD);
          check("ack_fail", fail, eF);
          check("ack_err", err, eE);
          pending = 0;
        end
      end
      for (int c = 0; c < CHN; c++) begin
        check("m_vld", mVld[c], outQ[c].size() != 0);
        if (outQ[c].size() != 0) check("m_head", {mCtl[c], mDat[c*DW +: DW]}, outQ[c][0]);
        check("s_rdy", sRdy[c], inQ[c].size() < DEPTH);
      end
    end
  end

  task automatic startReq(input bit w, input int ch, input logic [1:0] t, input logic [31:0] d);
    stb = 1; wre = w; adr = ch[4:0]; tga = t; datI = d;
    pWre = w; pCh = ch; pTga = t; pDat = d; pending = 1;
  endtask

  // Waits for ack; stream strobes are one-cycle pulses dropped at the first negedge.
  task automatic waitAck(input int maxCyc, output int lat, output logic [31:0] d,
                         output logic f, output logic e);
    lat = -1; d = '0; f = 0; e = 0;
    for (int k = 1; k <= maxCyc; k++) begin
      @(negedge clk);
      sVld = '0; mRdy = '0;
      if (ack) begin
        lat = k; d = datO; f = fail; e = err; stb = 0;
        break;
      end
    end
  endtask

  task automatic doReq(input bit w, input int ch, input logic [1:0] t, input logic [31:0] d,
                       output int lat, output logic [31:0] rd, output logic rf, output logic re);
    @(negedge clk);
    startReq(w, ch, t, d);
    waitAck(8, lat, rd, rf, re);
  endtask

  task automatic pushIn(input int ch, input logic c, input logic [31:0] d);
    @(negedge clk);
    sVld[ch] = 1; sCtl[ch] = c; sDat[ch*DW +: DW] = d;
    @(negedge clk);
    sVld[ch] = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  int          lat;
  logic [31:0] rd;
  logic        rf, re;
  logic [31:0] got [DEPTH];

  initial begin
    repeat (3) @(negedge clk);
    started = 1;
    check("rst_ack", ack, 0);
    check("rst_fail", fail, 0);
    check("rst_err", err, 0);
    check("rst_dat", datO, 0);
    check("rst_mvld", mVld, 0);
    check("rst_srdy", sRdy, 4'hF);
    rstN = 1;

    // Reset while a blocking GET waits; also discards a queued PUT word.
    doReq(1, 2, 2'b00, 32'h1234, lat, rd, rf, re);
    check("put_lat", lat, 1);
    @(negedge clk);
    startReq(0, 0, 2'b00, 0);
    waitAck(4, lat, rd, rf, re);
    check("get_blocks", lat, -1);
    rstN = 0; stb = 0;
    @(negedge clk);
    check("midrst_ack", ack, 0);
    check("midrst_mvld", mVld, 0);
    check("midrst_srdy", sRdy, 4'hF);
    rstN = 1;

    doReq(1, 1, 2'b00, 32'hDEADBEEF, lat, rd, rf, re);
    check("put1_lat", lat, 1);
    check("put1_fail", rf, 0);
    check("put1_mvld", mVld[1], 1);
    check("put1_mdat", mDat[63:32], 32'hDEADBEEF);
    check("put1_mctl", mCtl[1], 0);
    mRdy[1] = 1;
    @(negedge clk);
    mRdy = '0;
    doReq(1, 1, 2'b10, 32'hA5, lat, rd, rf, re);
    check("putc_mctl", mCtl[1], 1);
    check("putc_mdat", mDat[63:32], 32'hA5);
    mRdy[1] = 1;
    @(negedge clk);
    mRdy = '0;

    // Full outbound FIFO on ch0.
    for (int i = 0; i < DEPTH; i++) begin
      doReq(1, 0, 2'b00, 32'h100 + i, lat, rd, rf, re);
      check("fill_lat", lat, 1);
    end
    doReq(1, 0, 2'b01, 32'h999, lat, rd, rf, re);
    check("nbput_lat", lat, 1);
    check("nbput_fail", rf, 1);
    @(negedge clk);
    startReq(1, 0, 2'b00, 32'h777);
    waitAck(4, lat, rd, rf, re);
    check("bput_blocks", lat, -1);
    mRdy[0] = 1;
    waitAck(6, lat, rd, rf, re);
    check("bput_lat", lat, 2);
    check("bput_fail", rf, 0);
    for (int i = 0; i < DEPTH; i++) begin
      got[i] = mDat[31:0];
      mRdy[0] = 1;
      @(negedge clk);
    end
    mRdy = '0;
    check("drain_first", got[0], 32'h101);
    check("drain_7th", got[6], 32'h107);
    check("drain_last", got[7], 32'h777);
    check("drain_empty", mVld[0], 0);

    // Non-blocking GET miss, then control-flag mismatch.
    doReq(0, 2, 2'b01, 0, lat, rd, rf, re);
    check("nbget_lat", lat, 1);
    check("nbget_dat", rd, 0);
    check("nbget_fail", rf, 1);
    check("nbget_err", re, 0);
    pushIn(2, 1, 32'd5);
    doReq(0, 2, 2'b00, 0, lat, rd, rf, re);
    check("ctlget_dat", rd, 5);
    check("ctlget_err", re, 1);
    check("ctlget_fail", rf, 0);
    doReq(0, 2, 2'b01, 0, lat, rd, rf, re);
    check("ctlget_empty", rf, 1);

    // Blocking GET satisfied by a stream word arriving while waiting.
    @(negedge clk);
    startReq(0, 3, 2'b00, 0);
    waitAck(3, lat, rd, rf, re);
    check("bget_blocks", lat, -1);
    sVld[3] = 1; sCtl[3] = 0; sDat[3*DW +: DW] = 32'h33;
    waitAck(6, lat, rd, rf, re);
    check("bget_lat", lat, CUT_LAT);
    check("bget_dat", rd, 32'h33);
    check("bget_err", re, 0);

    // Out-of-range channels, with a word parked on the aliasing channel 3.
    pushIn(3, 0, 32'hCAFE);
    doReq(0, 7, 2'b00, 0, lat, rd, rf, re);
    check("bad_lat", lat, 1);
    check("bad_fail", rf, 1);
    check("bad_err", re, 1);
    check("bad_dat", rd, 0);
    doReq(1, 5, 2'b00, 32'h55, lat, rd, rf, re);
    check("badput_err", re, 1);
    check("badput_mvld", mVld, 0);
    doReq(0, 3, 2'b00, 0, lat, rd, rf, re);
    check("alias_dat", rd, 32'hCAFE);
    check("alias_fail", rf, 0);

    // Inbound FIFO fill past DEPTH; extra words are refused.
    @(negedge clk);
    for (int i = 0; i < DEPTH + 2; i++) begin
      sVld[1] = 1; sCtl[1] = 0; sDat[1*DW +: DW] = 32'h200 + i;
      @(negedge clk);
    end
    sVld = '0;
    check("infull_srdy", sRdy[1], 0);
    for (int i = 0; i < DEPTH; i++) begin
      doReq(0, 1, 2'b00, 0, lat, rd, rf, re);
      check("inorder_dat", rd, 32'h200 + i);
    end
    doReq(0, 1, 2'b01, 0, lat, rd, rf, re);
    check("in_drained", rf, 1);

    // Push and pop on the same edge of a partly filled outbound FIFO.
    doReq(1, 2, 2'b00, 32'h11, lat, rd, rf, re);
    doReq(1, 2, 2'b00, 32'h22, lat, rd, rf, re);
    @(negedge clk);
    startReq(1, 2, 2'b00, 32'h33);
    mRdy[2] = 1;
    waitAck(6, lat, rd, rf, re);
    check("pp_lat", lat, 1);
    check("pp_head", mDat[2*DW +: DW], 32'h22);
    mRdy[2] = 1;
    @(negedge clk);
    check("pp_next", mDat[2*DW +: DW], 32'h33);
    @(negedge clk);
    mRdy = '0;
    check("pp_empty", mVld[2], 0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
